// File: rtl/xintf_bus_bridge.sv
// xintf_bus_bridge: DSP-side port of the XINTF dual-port BRAM pair.
// Brings the asynchronous C28x XINTF strobes, address and data into i_clk
// through one shared 2-FF pipeline, serves DSP reads from the FPGA->DSP RAM
// and commits DSP writes into the DSP->FPGA RAM. All outputs are registered.
//
// Handshake: there is no valid/ready pair here; one DSP strobe assertion
// (cs_n low with exactly one of rd_n/we_n low) is one access. The FSM only
// accepts a new access from IDLE, and only after the strobes have been seen
// inactive (after reset, and naturally via WAIT_END otherwise).
//
// Optional feature: define XINTF_TIMEOUT_EN to bound how long WAIT_END may
// hold the bus; without it, o_err[2] is constant 0 and WAIT_END waits forever.
module xintf_bus_bridge #(
    parameter int LAST_RX_ADDR = 10,
    parameter int TIMEOUT_CYC  = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_xintf_cs_n,
    input  logic        i_xintf_rd_n,
    input  logic        i_xintf_we_n,
    input  logic [9:0]  i_xintf_addr,
    input  logic [15:0] i_xintf_data,
    output logic [15:0] o_xintf_data,
    output logic        o_xintf_data_oe,
    output logic [8:0]  o_tx_ram_addr,
    output logic        o_tx_ram_ce,
    input  logic [15:0] i_tx_ram_dout,
    output logic [8:0]  o_rx_ram_addr,
    output logic [15:0] o_rx_ram_din,
    output logic        o_rx_ram_ce,
    output logic        o_rx_ram_we,
    output logic        o_rx_frame_done,
    output logic [15:0] o_rd_cnt,
    output logic [15:0] o_wr_cnt,
    output logic [2:0]  o_err,
    input  logic        i_err_clr
);

    localparam logic [8:0] LAST_ADDR9 = 9'(LAST_RX_ADDR);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_FETCH  = 3'd1,
        S_RD_LATCH  = 3'd2,
        S_WR_COMMIT = 3'd3,
        S_WAIT_END  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Synchroniser stages: *_m is the metastability stage, *_s the usable one.
    logic        cs_m, rd_m, we_m;
    logic [9:0]  addr_m;
    logic [15:0] data_m;
    logic        cs_s, rd_s, we_s;
    logic [9:0]  addr_s;
    logic [15:0] data_s;

    // Re-arm tracking after reset.
    logic [1:0]  fill;
    logic        armed;

    // Decode of the synchronised strobes.
    logic        released;
    logic        dec_rd_tx, dec_rd_rx, dec_wr_rx, dec_wr_tx, dec_both;
    logic        to_hit;

    // Read-region memory: set when the current read targets the RX region.
    logic        rd_zero;

    // Next values of the registered outputs.
    logic [15:0] data_nxt;
    logic        oe_nxt;
    logic [8:0]  tx_addr_nxt;
    logic        tx_ce_nxt;
    logic [8:0]  rx_addr_nxt;
    logic [15:0] rx_din_nxt;
    logic        rx_we_nxt;
    logic        frame_nxt;
    logic [15:0] rd_cnt_nxt;
    logic [15:0] wr_cnt_nxt;
    logic [2:0]  err_set;
    logic [2:0]  err_nxt;
    logic        rd_zero_nxt;

    // Two-flop synchroniser shared by strobes, address and data so that all
    // stage-2 values describe the same pin sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cs_m   <= 1'b1;
            rd_m   <= 1'b1;
            we_m   <= 1'b1;
            addr_m <= '0;
            data_m <= '0;
            cs_s   <= 1'b1;
            rd_s   <= 1'b1;
            we_s   <= 1'b1;
            addr_s <= '0;
            data_s <= '0;
        end else begin
            cs_m   <= i_xintf_cs_n;
            rd_m   <= i_xintf_rd_n;
            we_m   <= i_xintf_we_n;
            addr_m <= i_xintf_addr;
            data_m <= i_xintf_data;
            cs_s   <= cs_m;
            rd_s   <= rd_m;
            we_s   <= we_m;
            addr_s <= addr_m;
            data_s <= data_m;
        end
    end

    // Arm only once the synchroniser carries real pin samples again and
    // those samples show the strobes inactive; a strobe held through reset
    // therefore cannot start a new access.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fill  <= 2'd0;
            armed <= 1'b0;
        end else begin
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end
            if ((fill == 2'd2) && released) begin
                armed <= 1'b1;
            end
        end
    end

    assign released  = cs_s | (rd_s & we_s);
    assign dec_rd_tx = armed && (state == S_IDLE) && !cs_s && !rd_s &&  we_s && !addr_s[9];
    assign dec_rd_rx = armed && (state == S_IDLE) && !cs_s && !rd_s &&  we_s &&  addr_s[9];
    assign dec_wr_rx = armed && (state == S_IDLE) && !cs_s &&  rd_s && !we_s &&  addr_s[9];
    assign dec_wr_tx = armed && (state == S_IDLE) && !cs_s &&  rd_s && !we_s && !addr_s[9];
    assign dec_both  = armed && (state == S_IDLE) && !cs_s && !rd_s && !we_s;

`ifdef XINTF_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt;

    // Count cycles spent in WAIT_END; saturates so the timeout stays asserted
    // until the DSP finally releases the strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst || (state != S_WAIT_END)) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_hit = (state == S_WAIT_END) && !released && (to_cnt == TO_LAST);
`else
    assign to_hit = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (dec_rd_tx) begin
                    state_nxt = S_RD_FETCH;
                end else if (dec_rd_rx) begin
                    state_nxt = S_RD_LATCH;
                end else if (dec_wr_rx) begin
                    state_nxt = S_WR_COMMIT;
                end else if (dec_wr_tx || dec_both) begin
                    state_nxt = S_WAIT_END;
                end
            end
            S_RD_FETCH:  state_nxt = S_RD_LATCH;
            S_RD_LATCH:  state_nxt = S_WAIT_END;
            S_WR_COMMIT: state_nxt = S_WAIT_END;
            S_WAIT_END: begin
                if (released) begin
                    state_nxt = S_IDLE;
                end
            end
            default:     state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode: next values for every registered output.
    always_comb begin
        tx_ce_nxt   = dec_rd_tx;
        tx_addr_nxt = dec_rd_tx ? addr_s[8:0] : o_tx_ram_addr;
        rx_we_nxt   = dec_wr_rx;
        rx_addr_nxt = dec_wr_rx ? addr_s[8:0] : o_rx_ram_addr;
        rx_din_nxt  = dec_wr_rx ? data_s : o_rx_ram_din;
        frame_nxt   = (state == S_WR_COMMIT) && (o_rx_ram_addr == LAST_ADDR9);

        rd_zero_nxt = rd_zero;
        if (dec_rd_rx) begin
            rd_zero_nxt = 1'b1;
        end else if (dec_rd_tx) begin
            rd_zero_nxt = 1'b0;
        end

        data_nxt   = o_xintf_data;
        oe_nxt     = o_xintf_data_oe;
        rd_cnt_nxt = o_rd_cnt;
        wr_cnt_nxt = o_wr_cnt;

        if (state == S_RD_LATCH) begin
            data_nxt   = rd_zero ? 16'h0000 : i_tx_ram_dout;
            oe_nxt     = 1'b1;
            rd_cnt_nxt = o_rd_cnt + 16'd1;
        end
        if ((state == S_WAIT_END) && (released || to_hit)) begin
            oe_nxt = 1'b0;
        end
        if (state == S_WR_COMMIT) begin
            wr_cnt_nxt = o_wr_cnt + 16'd1;
        end

        // A set in the same cycle as a clear wins.
        err_set = {to_hit, dec_rd_rx | dec_wr_tx, dec_both};
        err_nxt = (i_err_clr ? 3'b000 : o_err) | err_set;
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_xintf_data    <= '0;
            o_xintf_data_oe <= 1'b0;
            o_tx_ram_addr   <= '0;
            o_tx_ram_ce     <= 1'b0;
            o_rx_ram_addr   <= '0;
            o_rx_ram_din    <= '0;
            o_rx_ram_ce     <= 1'b0;
            o_rx_ram_we     <= 1'b0;
            o_rx_frame_done <= 1'b0;
            o_rd_cnt        <= '0;
            o_wr_cnt        <= '0;
            o_err           <= '0;
            rd_zero         <= 1'b0;
        end else begin
            o_xintf_data    <= data_nxt;
            o_xintf_data_oe <= oe_nxt;
            o_tx_ram_addr   <= tx_addr_nxt;
            o_tx_ram_ce     <= tx_ce_nxt;
            o_rx_ram_addr   <= rx_addr_nxt;
            o_rx_ram_din    <= rx_din_nxt;
            o_rx_ram_ce     <= rx_we_nxt;
            o_rx_ram_we     <= rx_we_nxt;
            o_rx_frame_done <= frame_nxt;
            o_rd_cnt        <= rd_cnt_nxt;
            o_wr_cnt        <= wr_cnt_nxt;
            o_err           <= err_nxt;
            rd_zero         <= rd_zero_nxt;
        end
    end

endmodule

// File: tb/tb_xintf_bus_bridge.sv
// Testbench for xintf_bus_bridge: DSP strobe driver, TX RAM model, output
// monitor and a transaction-level reference model with an expected queue.
module tb_xintf_bus_bridge;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cs_n, rd_n, we_n;
    logic [9:0]  addr;
    logic [15:0] data;
    logic [15:0] xdata;
    logic        oe;
    logic [8:0]  tx_addr;
    logic        tx_ce;
    logic [15:0] tx_dout;
    logic [8:0]  rx_addr;
    logic [15:0] rx_din;
    logic        rx_ce, rx_we, frame_done;
    logic [15:0] rd_cnt, wr_cnt;
    logic [2:0]  err;
    logic        err_clr;

    xintf_bus_bridge #(.LAST_RX_ADDR(10), .TIMEOUT_CYC(20)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_xintf_cs_n(cs_n), .i_xintf_rd_n(rd_n), .i_xintf_we_n(we_n),
        .i_xintf_addr(addr), .i_xintf_data(data),
        .o_xintf_data(xdata), .o_xintf_data_oe(oe),
        .o_tx_ram_addr(tx_addr), .o_tx_ram_ce(tx_ce), .i_tx_ram_dout(tx_dout),
        .o_rx_ram_addr(rx_addr), .o_rx_ram_din(rx_din),
        .o_rx_ram_ce(rx_ce), .o_rx_ram_we(rx_we),
        .o_rx_frame_done(frame_done),
        .o_rd_cnt(rd_cnt), .o_wr_cnt(wr_cnt),
        .o_err(err), .i_err_clr(err_clr)
    );

    // ---------------- TX RAM (1-cycle read latency) ----------------
    logic [15:0] tx_mem [0:511];
    initial tx_dout = 16'h0000;
    always @(posedge clk) if (tx_ce) tx_dout <= tx_mem[tx_addr];

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_ce = 0, n_fd = 0;
    int          ce_cyc = 0, we_cyc = 0, fd_cyc = 0, rise_cyc = 0;
    logic [8:0]  ce_addr = '0;
    logic        oe_prev = 1'b0;
    logic [25:0] obs_q[$];

    always @(negedge clk) begin
        if (tx_ce) begin
            n_ce    <= n_ce + 1;
            ce_cyc  <= cyc;
            ce_addr <= tx_addr;
        end
        if (rx_we) begin
            we_cyc <= cyc;
            obs_q.push_back({rx_ce, rx_addr, rx_din});
        end
        if (frame_done) begin
            n_fd   <= n_fd + 1;
            fd_cyc <= cyc;
        end
        if (oe && !oe_prev) rise_cyc <= cyc;
        oe_prev <= oe;
    end

    // ---------------- reference model / scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_rd = '0, m_wr = '0;
    logic [2:0]  m_err = '0;
    int          m_ce = 0, m_fd = 0;
    logic [25:0] exp_q[$];

    // kind: 0 = read, 1 = write, 2 = rd_n and we_n both low
    task automatic model_step(input int kind, input logic [9:0] a, input logic [15:0] d,
                              output logic [15:0] exp_data, output logic exp_oe);
        exp_data = 16'h0000;
        exp_oe   = 1'b0;
        if (kind == 0) begin
            exp_oe = 1'b1;
            m_rd   = m_rd + 16'd1;
            if (!a[9]) begin
                exp_data = tx_mem[a[8:0]];
                m_ce     = m_ce + 1;
            end else begin
                m_err[1] = 1'b1;
            end
        end else if (kind == 1) begin
            if (a[9]) begin
                exp_q.push_back({1'b1, a[8:0], d});
                m_wr = m_wr + 16'd1;
                if (a[8:0] == 9'd10) m_fd = m_fd + 1;
            end else begin
                m_err[1] = 1'b1;
            end
        end else begin
            m_err[0] = 1'b1;
        end
    endtask

    // ---------------- driver ----------------
    logic [15:0] rdata;
    logic        oe_mid, oe_end;
    logic [15:0] ed;
    logic        eo;
    logic [25:0] ev, ov;

    // Data/address set up 3 cycles before the strobe, strobe active 8 cycles,
    // sample the bus after 7, then check the bus enable 4 cycles after release.
    task automatic dsp_access(input int kind, input logic [9:0] a, input logic [15:0] d,
                              output logic [15:0] rd_v, output logic oe_m, output logic oe_e);
        @(posedge clk); #1;
        addr = a; data = d; cs_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (kind != 1) rd_n = 1'b0;
        if (kind != 0) we_n = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rd_v = xdata;
        oe_m = oe;
        @(posedge clk); #1;
        rd_n = 1'b1; we_n = 1'b1; cs_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        oe_e = oe;
        repeat (2) @(posedge clk);
    endtask

    task automatic pulse_err_clr();
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        m_err = 3'b000;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({xdata, oe, tx_addr, tx_ce, rx_addr, rx_din, rx_ce, rx_we, frame_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h oe=%b txa=%h txce=%b rxa=%h din=%h rxce=%b we=%b fd=%b expected all 0",
                     xdata, oe, tx_addr, tx_ce, rx_addr, rx_din, rx_ce, rx_we, frame_done);
        end
        checks++;
        if ({rd_cnt, wr_cnt, err} !== '0) begin
            errors++;
            $display("FAIL reset_counters: got rd=%h wr=%h err=%b expected 0", rd_cnt, wr_cnt, err);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_read_basic();
        tx_mem[5] = 16'hA5C3;
        model_step(0, 10'h005, 16'h0000, ed, eo);
        dsp_access(0, 10'h005, 16'h0000, rdata, oe_mid, oe_end);
        checks++;
        if (rdata !== 16'hA5C3) begin errors++; $display("FAIL read_data: got %h expected a5c3", rdata); end
        checks++;
        if (oe_mid !== 1'b1) begin errors++; $display("FAIL read_oe: got %b expected 1", oe_mid); end
        checks++;
        if (oe_end !== 1'b0) begin errors++; $display("FAIL read_oe_release: got %b expected 0", oe_end); end
        checks++;
        if (n_ce !== m_ce) begin errors++; $display("FAIL read_ce_count: got %0d expected %0d", n_ce, m_ce); end
        checks++;
        if (ce_addr !== 9'h005) begin errors++; $display("FAIL read_ce_addr: got %h expected 005", ce_addr); end
        checks++;
        if (rise_cyc - ce_cyc !== 2) begin
            errors++; $display("FAIL read_ce_to_oe: got %0d cycles expected 2", rise_cyc - ce_cyc);
        end
        checks++;
        if (rd_cnt !== m_rd) begin errors++; $display("FAIL read_cnt: got %h expected %h", rd_cnt, m_rd); end
        checks++;
        if (err !== 3'b000) begin errors++; $display("FAIL read_err: got %b expected 000", err); end
    endtask

    task automatic test_write_frame();
        model_step(1, 10'h20A, 16'h1234, ed, eo);
        dsp_access(1, 10'h20A, 16'h1234, rdata, oe_mid, oe_end);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL write_count: got %0d writes expected 1", obs_q.size());
        end
        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL write_port: got none expected %h", ev);
            end else begin
                ov = obs_q.pop_front();
                if (ov !== ev) begin errors++; $display("FAIL write_port: got %h expected %h", ov, ev); end
            end
        end
        obs_q.delete();
        checks++;
        if (n_fd !== m_fd) begin errors++; $display("FAIL frame_done_count: got %0d expected %0d", n_fd, m_fd); end
        checks++;
        if (fd_cyc - we_cyc !== 1) begin
            errors++; $display("FAIL frame_done_timing: got %0d cycles after we expected 1", fd_cyc - we_cyc);
        end
        checks++;
        if (wr_cnt !== m_wr) begin errors++; $display("FAIL write_cnt: got %h expected %h", wr_cnt, m_wr); end
        checks++;
        if (oe_mid !== 1'b0) begin errors++; $display("FAIL write_oe: got %b expected 0", oe_mid); end
    endtask

    task automatic test_region_err();
        model_step(1, 10'h003, 16'hBEEF, ed, eo);
        dsp_access(1, 10'h003, 16'hBEEF, rdata, oe_mid, oe_end);
        checks++;
        if (obs_q.size() !== 0) begin
            errors++; $display("FAIL tx_region_write: got %0d writes expected 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if (err !== 3'b010) begin errors++; $display("FAIL region_err_write: got %b expected 010", err); end
        tx_mem[1] = 16'hFFFF;
        model_step(0, 10'h201, 16'h0000, ed, eo);
        dsp_access(0, 10'h201, 16'h0000, rdata, oe_mid, oe_end);
        checks++;
        if (rdata !== 16'h0000) begin errors++; $display("FAIL rx_region_read: got %h expected 0000", rdata); end
        checks++;
        if (n_ce !== m_ce) begin errors++; $display("FAIL rx_region_ce: got %0d expected %0d", n_ce, m_ce); end
        checks++;
        if (oe_mid !== 1'b1) begin errors++; $display("FAIL rx_region_oe: got %b expected 1", oe_mid); end
        checks++;
        if (err !== m_err) begin errors++; $display("FAIL region_err_read: got %b expected %b", err, m_err); end
        checks++;
        if (rd_cnt !== m_rd) begin errors++; $display("FAIL rx_region_cnt: got %h expected %h", rd_cnt, m_rd); end
    endtask

    task automatic test_protocol_err();
        pulse_err_clr();
        model_step(2, 10'h210, 16'h5555, ed, eo);
        dsp_access(2, 10'h210, 16'h5555, rdata, oe_mid, oe_end);
        checks++;
        if (err !== 3'b001) begin errors++; $display("FAIL protocol_err: got %b expected 001", err); end
        checks++;
        if (n_ce !== m_ce || obs_q.size() !== 0) begin
            errors++; $display("FAIL protocol_no_access: got ce=%0d writes=%0d expected ce=%0d writes=0",
                               n_ce, obs_q.size(), m_ce);
            obs_q.delete();
        end
        checks++;
        if (oe_mid !== 1'b0) begin errors++; $display("FAIL protocol_oe: got %b expected 0", oe_mid); end
        pulse_err_clr();
        @(negedge clk);
        checks++;
        if (err !== 3'b000) begin errors++; $display("FAIL err_clear: got %b expected 000", err); end
    endtask

    task automatic test_random();
        int kind;
        logic [9:0]  a;
        logic [15:0] d;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 2);
            a    = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) a = 10'h20A;
            d    = 16'($urandom);
            if ($urandom_range(0, 1) == 0) pulse_err_clr();
            model_step(kind, a, d, ed, eo);
            dsp_access(kind, a, d, rdata, oe_mid, oe_end);
            if (kind == 0) begin
                checks++;
                if (rdata !== ed) begin
                    errors++; $display("FAIL rand_read_data[%0d]: addr %h got %h expected %h", i, a, rdata, ed);
                end
            end
            checks++;
            if (oe_mid !== eo || oe_end !== 1'b0) begin
                errors++; $display("FAIL rand_oe[%0d]: got mid=%b end=%b expected mid=%b end=0", i, oe_mid, oe_end, eo);
            end
            while (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                checks++;
                if (obs_q.size() == 0) begin
                    errors++; $display("FAIL rand_write[%0d]: got none expected %h", i, ev);
                end else begin
                    ov = obs_q.pop_front();
                    if (ov !== ev) begin errors++; $display("FAIL rand_write[%0d]: got %h expected %h", i, ov, ev); end
                end
            end
            checks++;
            if (obs_q.size() !== 0) begin
                errors++; $display("FAIL rand_extra_write[%0d]: got %0d extra expected 0", i, obs_q.size());
                obs_q.delete();
            end
            checks++;
            if (rd_cnt !== m_rd || wr_cnt !== m_wr) begin
                errors++; $display("FAIL rand_cnt[%0d]: got rd=%h wr=%h expected rd=%h wr=%h", i, rd_cnt, wr_cnt, m_rd, m_wr);
            end
            checks++;
            if (err !== m_err) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", i, err, m_err); end
            checks++;
            if (n_ce !== m_ce || n_fd !== m_fd) begin
                errors++; $display("FAIL rand_ce_fd[%0d]: got ce=%0d fd=%0d expected ce=%0d fd=%0d", i, n_ce, n_fd, m_ce, m_fd);
            end
        end
    endtask

    task automatic test_reset_mid();
        tx_mem[7] = 16'h5A17;
        model_step(0, 10'h007, 16'h0000, ed, eo);
        @(posedge clk); #1;
        addr = 10'h007; cs_n = 1'b0; rd_n = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        checks++;
        if (oe !== 1'b1 || xdata !== 16'h5A17) begin
            errors++; $display("FAIL rst_mid_pre: got oe=%b data=%h expected oe=1 data=5a17", oe, xdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_rd = '0; m_wr = '0; m_err = '0;
        checks++;
        if (oe !== 1'b0 || rd_cnt !== m_rd) begin
            errors++; $display("FAIL rst_mid_oe: got oe=%b rd=%h expected oe=0 rd=0", oe, rd_cnt);
        end
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++;
        if (n_ce !== m_ce || oe !== 1'b0 || rd_cnt !== m_rd) begin
            errors++; $display("FAIL rst_mid_no_rearm: got ce=%0d oe=%b rd=%h expected ce=%0d oe=0 rd=0",
                               n_ce, oe, rd_cnt, m_ce);
        end
        @(posedge clk); #1;
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (5) @(posedge clk);
        model_step(0, 10'h007, 16'h0000, ed, eo);
        dsp_access(0, 10'h007, 16'h0000, rdata, oe_mid, oe_end);
        checks++;
        if (rdata !== ed || rd_cnt !== m_rd || n_ce !== m_ce) begin
            errors++; $display("FAIL rst_mid_rearm: got data=%h rd=%h ce=%0d expected data=%h rd=%h ce=%0d",
                               rdata, rd_cnt, n_ce, ed, m_rd, m_ce);
        end
    endtask

    task automatic test_long_hold();
        tx_mem[12] = 16'h0C0C;
        model_step(0, 10'h00C, 16'h0000, ed, eo);
        @(posedge clk); #1;
        addr = 10'h00C; cs_n = 1'b0; rd_n = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++;
        if (oe !== 1'b1 || xdata !== ed) begin
            errors++; $display("FAIL hold_early: got oe=%b data=%h expected oe=1 data=%h", oe, xdata, ed);
        end
        repeat (26) @(posedge clk);
        @(negedge clk);
`ifdef XINTF_TIMEOUT_EN
        m_err[2] = 1'b1;
        checks++;
        if (oe !== 1'b0) begin errors++; $display("FAIL timeout_oe: got %b expected 0", oe); end
`else
        checks++;
        if (oe !== 1'b1) begin errors++; $display("FAIL hold_oe: got %b expected 1", oe); end
`endif
        checks++;
        if (err !== m_err) begin errors++; $display("FAIL hold_err: got %b expected %b", err, m_err); end
        @(posedge clk); #1;
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (oe !== 1'b0 || rd_cnt !== m_rd || n_ce !== m_ce) begin
            errors++; $display("FAIL hold_release: got oe=%b rd=%h ce=%0d expected oe=0 rd=%h ce=%0d",
                               oe, rd_cnt, n_ce, m_rd, m_ce);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- sequence ----------------
    initial begin
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; we_n = 1'b1;
        addr = '0; data = '0; err_clr = 1'b0;
        for (int i = 0; i < 512; i++) tx_mem[i] = 16'($urandom);
        test_reset();
        test_read_basic();
        test_write_frame();
        test_region_err();
        test_protocol_err();
        test_random();
        test_reset_mid();
        test_long_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
